// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: loads one 512-bit block as 16 words and streams
// W[0..ROUNDS-1] with round index, expanding on the fly through a 16-word window.
module sha256_msg_scheduler #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] w_data,
  output logic [6:0]  w_iter,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        w_last,
  output logic        busy
);

  if (ROUNDS < 16 || ROUNDS > 64) begin : g_bad_rounds
    $error("sha256_msg_scheduler: ROUNDS must be in 16..64");
  end

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  state_e      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [6:0]  t, t_nxt;
  logic [31:0] win [16];
  logic        accept, xfer, shift;
  logic [31:0] shift_in, expanded;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  assign in_ready = (state == LOAD);
  assign w_valid  = (state == EMIT);
  assign w_data   = win[0];
  assign w_iter   = t;
  assign w_last   = (state == EMIT) && (t == LAST_T);
  assign busy     = (count != 4'd0) || (state == EMIT);

  assign accept   = in_valid && in_ready;
  assign xfer     = w_valid && w_ready;

  // W[t+16] from the window holding W[t..t+15]; 32-bit adds wrap mod 2^32.
  assign expanded = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    t_nxt     = t;
    shift     = 1'b0;
    shift_in  = in_data;
    unique case (state)
      LOAD: begin
        if (accept) begin
          shift = 1'b1;
          if (count == 4'd15) begin
            count_nxt = 4'd0;
            t_nxt     = 7'd0;
            state_nxt = EMIT;
          end else begin
            count_nxt = count + 4'd1;
          end
        end
      end
      EMIT: begin
        if (xfer) begin
          shift    = 1'b1;
          shift_in = expanded;
          if (t == LAST_T) begin
            t_nxt     = 7'd0;
            state_nxt = LOAD;
          end else begin
            t_nxt = t + 7'd1;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      count <= 4'd0;
      t     <= 7'd0;
      // NOTE: the window is reset (not left as plain storage) because w_data
      // is read straight from win[0] and must be 0 after reset.
      for (int i = 0; i < 16; i++) win[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      t     <= t_nxt;
      if (shift) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= shift_in;
      end
    end
  end

endmodule
